// File: rtl/instruction_fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package instruction_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_DEFAULT      = 32'h0000_0000;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait
    } fetch_state_e;

    // Sequential fetch address; wraps modulo 2^32.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/response bus between fetch (master) and memory (slave).
interface instruction_fetch_if;
    import instruction_fetch_pkg::*;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/pc_register.sv
// Program counter with redirect load and sequential increment.
module pc_register
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        increment,
    output logic [31:0] pc
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    // Redirect beats increment so a target coinciding with request acceptance wins.
    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = redirect_target;
        end else if (increment) begin
            pc_d = next_pc(pc_q);
        end
    end

    // PC state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: one outstanding imem request, single-entry output buffer, redirect handling.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP      = NOP_DEFAULT
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       PCWrite,
    input  logic                       branch_taken,
    input  logic [31:0]                branch_target,
    input  logic                       jump,
    input  logic [31:0]                jump_target,
    instruction_fetch_if.master        imem,
    output logic [31:0]                Inst,
    output logic [31:0]                PC_Plus4,
    output logic                       inst_valid,
    output logic                       flush
);

    fetch_state_e state_q, state_d;
    logic         drop_q, drop_d;
    logic [31:0]  fetch_addr_q;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  pc_plus4_q, pc_plus4_d;
    logic         inst_valid_q, inst_valid_d;

    logic         redirect;
    logic [31:0]  redirect_target;
    logic         consume;
    logic         buf_free;
    logic         accept;
    logic         response;
    logic         load;
    logic [31:0]  pc;

    assign redirect        = branch_taken | jump;
    assign redirect_target = branch_taken ? branch_target : jump_target;
    assign consume         = PCWrite & inst_valid_q;
    // A new request may only be issued if its result will have somewhere to land.
    assign buf_free        = ~inst_valid_q | consume;
    assign accept          = imem.imem_req & imem.imem_ready;
    assign response        = (state_q == StWait) & imem.imem_rvalid;
    assign load            = response & ~drop_q & ~redirect;

    pc_register #(
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clock           (clock),
        .reset           (reset),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .increment       (accept),
        .pc              (pc)
    );

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: one request in flight at a time.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  state_d = StReq;
            StReq:   if (accept) state_d = StWait;
            StWait:  if (imem.imem_rvalid) state_d = StReq;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: request only from REQ when the buffer can take the result.
    always_comb begin
        imem.imem_req  = (state_q == StReq) & buf_free;
        imem.imem_addr = pc;
    end

    // Drop tracks an in-flight response that belongs to the pre-redirect path.
    always_comb begin
        drop_d = drop_q;
        if (response) begin
            drop_d = 1'b0;
        end
        if (redirect && (((state_q == StWait) && !imem.imem_rvalid) || accept)) begin
            drop_d = 1'b1;
        end
    end

    // Output buffer next-state: redirect clears, a response loads, consumption empties.
    always_comb begin
        inst_d       = inst_q;
        pc_plus4_d   = pc_plus4_q;
        inst_valid_d = inst_valid_q;
        if (redirect) begin
            inst_valid_d = 1'b0;
        end else if (load) begin
            inst_d       = imem.imem_rdata;
            pc_plus4_d   = next_pc(fetch_addr_q);
            inst_valid_d = 1'b1;
        end else if (consume) begin
            inst_valid_d = 1'b0;
        end
    end

    // Drop flag, fetch address and output buffer registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop_q       <= 1'b0;
            fetch_addr_q <= RESET_PC;
            inst_q       <= NOP;
            pc_plus4_q   <= 32'h0;
            inst_valid_q <= 1'b0;
        end else begin
            drop_q <= drop_d;
            if (accept) begin
                fetch_addr_q <= pc;
            end
            inst_q       <= inst_d;
            pc_plus4_q   <= pc_plus4_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    assign Inst       = inst_valid_q ? inst_q : NOP;
    assign PC_Plus4   = inst_valid_q ? pc_plus4_q : 32'h0;
    assign inst_valid = inst_valid_q;
    assign flush      = redirect;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch with a behavioural memory and result scoreboard.
module tb_instruction_fetch;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TB_NOP      = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset;
    logic        PCWrite;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] Inst;
    logic [31:0] PC_Plus4;
    logic        inst_valid;
    logic        flush;

    instruction_fetch_if imem_bus ();

    instruction_fetch #(
        .RESET_PC (TB_RESET_PC),
        .NOP      (TB_NOP)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .PCWrite       (PCWrite),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem          (imem_bus),
        .Inst          (Inst),
        .PC_Plus4      (PC_Plus4),
        .inst_valid    (inst_valid),
        .flush         (flush)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc4;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic        mem_pend;
    logic [31:0] mem_addr;
    int          mem_cnt;
    int          resp_delay;
    logic        tb_drop;
    logic [31:0] tb_pc;
    logic        last_acc;
    logic [31:0] last_acc_addr;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h2001_0005 : ((a ^ 32'h5A00_0000) + 32'h13);
    endfunction

    task automatic check_reset_outputs();
        check("rst_valid", 32'(inst_valid), 0);
        check("rst_inst", Inst, TB_NOP);
        check("rst_pc4", PC_Plus4, 0);
        check("rst_req", 32'(imem_bus.imem_req), 0);
        check("rst_addr", imem_bus.imem_addr, TB_RESET_PC);
    endtask

    // One clock: drive memory response, observe request, model PC/drop, check loads.
    task automatic cycle();
        logic        deliver;
        logic        keep;
        logic        acc;
        logic        redir;
        logic [31:0] tgt;
        exp_t        e;
        deliver = 1'b0;
        if (mem_pend) begin
            if (mem_cnt == 0) deliver = 1'b1;
            else mem_cnt--;
        end
        imem_bus.imem_rvalid = deliver;
        imem_bus.imem_rdata  = deliver ? mem_word(mem_addr) : 32'hDEAD_BEEF;
        #1;
        redir = branch_taken | jump;
        tgt   = branch_taken ? branch_target : jump_target;
        check("flush", 32'(flush), 32'(redir));
        if (mem_pend && !deliver) check("req_in_wait", 32'(imem_bus.imem_req), 0);
        acc = imem_bus.imem_req & imem_bus.imem_ready;
        last_acc = acc;
        if (acc) begin
            last_acc_addr = imem_bus.imem_addr;
            check("imem_addr", imem_bus.imem_addr, tb_pc);
        end
        keep = deliver & ~tb_drop & ~redir;
        if (keep) sb.push_back('{inst: mem_word(mem_addr), pc4: mem_addr + 32'd4});
        if (redir && ((mem_pend && !deliver) || acc)) tb_drop = 1'b1;
        else if (deliver) tb_drop = 1'b0;
        if (deliver) mem_pend = 1'b0;
        if (acc) begin
            mem_pend = 1'b1;
            mem_addr = imem_bus.imem_addr;
            mem_cnt  = resp_delay - 1;
        end
        if (redir) tb_pc = tgt;
        else if (acc) tb_pc = tb_pc + 32'd4;
        @(posedge clock);
        @(negedge clock);
        if (keep) begin
            e = sb.pop_front();
            check("load_valid", 32'(inst_valid), 1);
            check("load_inst", Inst, e.inst);
            check("load_pc4", PC_Plus4, e.pc4);
        end else if (deliver) begin
            check("dropped_valid", 32'(inst_valid), 0);
        end
    endtask

    task automatic run_to_accept();
        last_acc = 1'b0;
        for (int i = 0; i < 20 && !last_acc; i++) cycle();
        check("accept_timeout", 32'(last_acc), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; PCWrite = 1'b0;
        branch_taken = 1'b0; branch_target = 32'h0; jump = 1'b0; jump_target = 32'h0;
        imem_bus.imem_ready = 1'b1; imem_bus.imem_rvalid = 1'b0; imem_bus.imem_rdata = 32'h0;
        mem_pend = 1'b0; mem_addr = 32'h0; mem_cnt = 0; resp_delay = 1;
        tb_drop = 1'b0; tb_pc = TB_RESET_PC; last_acc = 1'b0; last_acc_addr = 32'h0;

        @(negedge clock); #1;
        check_reset_outputs();
        @(negedge clock);
        reset = 1'b0;
        #1 check("idle_req", 32'(imem_bus.imem_req), 0);
        cycle();

        // First fetch with one-cycle memory.
        #1 check("first_req", 32'(imem_bus.imem_req), 1);
        check("first_addr", imem_bus.imem_addr, 32'h0);
        cycle();
        cycle();
        check("inst_first", Inst, 32'h2001_0005);
        check("pc4_first", PC_Plus4, 32'h4);

        // Stall holds the buffer and suppresses requests.
        #1 check("stall_req", 32'(imem_bus.imem_req), 0);
        cycle();
        cycle();
        check("stall_inst", Inst, 32'h2001_0005);
        check("stall_valid", 32'(inst_valid), 1);
        PCWrite = 1'b1;
        #1 check("release_req", 32'(imem_bus.imem_req), 1);
        check("release_addr", imem_bus.imem_addr, 32'h4);
        cycle();
        check("consumed_valid", 32'(inst_valid), 0);
        cycle();

        // Streaming.
        repeat (8) cycle();

        // Branch while waiting drops the stale response.
        resp_delay = 3;
        run_to_accept();
        branch_taken = 1'b1; branch_target = 32'h40;
        cycle();
        branch_taken = 1'b0;
        check("branch_wait_valid", 32'(inst_valid), 0);
        run_to_accept();
        check("branch_wait_addr", last_acc_addr, 32'h40);

        // Branch has priority over jump.
        resp_delay = 2;
        run_to_accept();
        branch_taken = 1'b1; branch_target = 32'h80; jump = 1'b1; jump_target = 32'hC0;
        cycle();
        branch_taken = 1'b0; jump = 1'b0;
        run_to_accept();
        check("priority_addr", last_acc_addr, 32'h80);

        // Redirect coinciding with a response discards it without arming drop.
        resp_delay = 1;
        run_to_accept();
        jump = 1'b1; jump_target = 32'h10;
        cycle();
        jump = 1'b0;
        check("resp_redirect_valid", 32'(inst_valid), 0);
        #1 check("resp_redirect_req", 32'(imem_bus.imem_req), 1);
        check("resp_redirect_addr", imem_bus.imem_addr, 32'h10);

        // Redirect coinciding with acceptance at 0x10.
        branch_taken = 1'b1; branch_target = 32'h200;
        cycle();
        branch_taken = 1'b0;
        check("accept_redirect_acc", 32'(last_acc), 1);
        run_to_accept();
        check("accept_redirect_addr", last_acc_addr, 32'h200);

        // Memory not ready: request stays pending.
        cycle();
        imem_bus.imem_ready = 1'b0;
        repeat (3) cycle();
        #1 check("notready_req", 32'(imem_bus.imem_req), 1);
        imem_bus.imem_ready = 1'b1;
        run_to_accept();

        // Redirect overrides a stall and clears a full buffer.
        PCWrite = 1'b0;
        for (int i = 0; i < 10 && !inst_valid; i++) cycle();
        check("fill_valid", 32'(inst_valid), 1);
        branch_taken = 1'b1; branch_target = 32'h300;
        cycle();
        branch_taken = 1'b0;
        check("stall_redirect_valid", 32'(inst_valid), 0);
        check("stall_redirect_inst", Inst, TB_NOP);
        PCWrite = 1'b1;
        run_to_accept();
        check("stall_redirect_addr", last_acc_addr, 32'h300);

        // Reset in the middle of WAIT.
        resp_delay = 3;
        run_to_accept();
        cycle();
        reset = 1'b1;
        imem_bus.imem_rvalid = 1'b0;
        #1 check_reset_outputs();
        mem_pend = 1'b0; tb_drop = 1'b0; tb_pc = TB_RESET_PC;
        sb.delete();
        @(negedge clock);
        reset = 1'b0;
        #1 check("post_rst_idle_req", 32'(imem_bus.imem_req), 0);
        cycle();
        run_to_accept();
        check("post_rst_addr", last_acc_addr, TB_RESET_PC);
        repeat (3) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
